// File: rtl/messbauer_channel_sequencer.sv
// messbauer_channel_sequencer: swept-dwell Mossbauer spectrum accumulator.
// Each start pulse sweeps channels 0..last_channel and adds each channel's pulse count to memory by RMW.
module messbauer_channel_sequencer #(
   parameter int CHANNEL_WIDTH = 12,
   parameter int COUNT_WIDTH   = 24,
   parameter int DWELL_WIDTH   = 16,
   parameter int PULSE_WIDTH   = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic [DWELL_WIDTH-1:0]   dwell,
   input  logic [CHANNEL_WIDTH-1:0] last_channel,
   input  logic                     start,
   input  logic                     detector_pulse,
   input  logic                     clear_status,
   output logic [CHANNEL_WIDTH-1:0] mem_addr,
   output logic                     mem_rd,
   input  logic [COUNT_WIDTH-1:0]   mem_rdata,
   output logic                     mem_wr,
   output logic [COUNT_WIDTH-1:0]   mem_wdata,
   output logic [CHANNEL_WIDTH-1:0] channel,
   output logic                     channel_advance,
   output logic [31:0]              cycle_count,
   output logic                     busy,
   output logic                     overflow,
   output logic                     sync_err
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_DWELL = 2'd2;
   localparam logic [1:0] R_IDLE  = 2'd0;
   localparam logic [1:0] R_RD    = 2'd1;
   localparam logic [1:0] R_WAIT  = 2'd2;
   localparam logic [1:0] R_WR    = 2'd3;
   logic [1:0]             state, state_nxt, rmw, rmw_nxt;
   logic [DWELL_WIDTH-1:0] dcnt, d_eff;
   logic [PULSE_WIDTH-1:0] pcnt, pcnt_inc, pending;
   logic                   pcnt_full, last_cycle, sweep_end, sweep_go;
   logic [COUNT_WIDTH:0]   sum;
   always_comb begin
      d_eff      = dwell < DWELL_WIDTH'(4) ? DWELL_WIDTH'(4) : dwell;
      pcnt_full  = &pcnt;
      pcnt_inc   = pcnt + PULSE_WIDTH'(detector_pulse && !pcnt_full);
      last_cycle = state == S_DWELL && dcnt == DWELL_WIDTH'(1);
      sweep_end  = last_cycle && channel == last_channel;
      sweep_go   = state == S_ARMED && enable && start;
      state_nxt  = state == S_IDLE  ? (enable ? S_ARMED : S_IDLE)
                 : state == S_ARMED ? (!enable ? S_IDLE : start ? S_DWELL : S_ARMED)
                 : state == S_DWELL ? (!sweep_end ? S_DWELL : enable ? S_ARMED : S_IDLE)
                 : S_IDLE;
      // RMW runs RD -> WAIT -> WR; a dwell of at least 4 keeps launches from overlapping
      rmw_nxt    = rmw == R_RD ? R_WAIT : rmw == R_WAIT ? R_WR : last_cycle ? R_RD : R_IDLE;
      sum        = {1'b0, mem_rdata} + (COUNT_WIDTH + 1)'(pending);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         rmw             <= R_IDLE;
         dcnt            <= '0;
         pcnt            <= '0;
         pending         <= '0;
         mem_addr        <= '0;
         mem_rd          <= 1'b0;
         mem_wr          <= 1'b0;
         mem_wdata       <= '0;
         channel         <= '0;
         channel_advance <= 1'b0;
         cycle_count     <= '0;
         busy            <= 1'b0;
         overflow        <= 1'b0;
         sync_err        <= 1'b0;
      end else begin
         state           <= state_nxt;
         rmw             <= rmw_nxt;
         busy            <= state_nxt == S_DWELL || rmw_nxt != R_IDLE;
         channel_advance <= sweep_go || (last_cycle && !sweep_end);
         mem_rd          <= rmw_nxt == R_RD;
         mem_wr          <= rmw_nxt == R_WR;
         if (sweep_go) begin
            channel <= '0;
            dcnt    <= d_eff;
            pcnt    <= '0;
         end else if (state == S_DWELL) begin
            dcnt <= last_cycle ? d_eff : dcnt - DWELL_WIDTH'(1);
            pcnt <= last_cycle ? '0 : pcnt_inc;
            if (last_cycle && !sweep_end) channel <= channel + CHANNEL_WIDTH'(1);
         end
         if (last_cycle) begin
            pending  <= pcnt_inc;
            mem_addr <= channel;
         end
         if (sweep_end) cycle_count <= cycle_count + 32'd1;
         if (rmw == R_WAIT) mem_wdata <= sum[COUNT_WIDTH] ? {COUNT_WIDTH{1'b1}} : sum[COUNT_WIDTH-1:0];
         overflow <= (state == S_DWELL && detector_pulse && pcnt_full) ||
                     (rmw == R_WAIT && sum[COUNT_WIDTH]) || (overflow && !clear_status);
         sync_err <= (state == S_DWELL && start) || (sync_err && !clear_status);
      end
   end
endmodule

// File: tb/tb_messbauer_channel_sequencer.sv
// tb_messbauer_channel_sequencer: randomized sweeps against a per-channel counting model.
// The bench owns the spectrum memory and logs every strobe with its cycle number.
module tb_messbauer_channel_sequencer;
   localparam int CW = 12, NW = 24, DW = 16, PW = 8;
   localparam int MAXC = 'hFFFFFF, MAXP = (1 << PW) - 1;
   logic clk = 0, rst_n = 0, enable = 0, start = 0, detector_pulse = 0, clear_status = 0;
   logic [DW-1:0] dwell = 4;
   logic [CW-1:0] last_channel = 0;
   logic [CW-1:0] mem_addr, channel;
   logic mem_rd, mem_wr, channel_advance, busy, overflow, sync_err;
   logic [NW-1:0] mem_rdata = '0, mem_wdata;
   logic [31:0] cycle_count;
   int vectors = 0, errors = 0, cyc = 0, clash = 0;
   bit [NW-1:0] mem [0:(1<<CW)-1];
   int exp_mem [0:(1<<CW)-1];
   int wr_addr[$], wr_data[$], wr_cyc[$], rd_cyc[$];
   bit pre_en = 0;
   int pre_addr = 0;
   bit [NW-1:0] pre_data = '0;
   bit pat[];
   int exp_cycles = 0;
   bit exp_ovf = 0, exp_sync = 0;

   messbauer_channel_sequencer dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .dwell(dwell), .last_channel(last_channel),
      .start(start), .detector_pulse(detector_pulse), .clear_status(clear_status),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .channel(channel), .channel_advance(channel_advance),
      .cycle_count(cycle_count), .busy(busy), .overflow(overflow), .sync_err(sync_err));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_rd && mem_wr) clash <= clash + 1;
      if (mem_rd) begin
         mem_rdata <= mem[mem_addr];
         rd_cyc.push_back(cyc);
      end
      if (mem_wr) begin
         mem[mem_addr] <= mem_wdata;
         wr_addr.push_back(int'(mem_addr));
         wr_data.push_back(int'(mem_wdata));
         wr_cyc.push_back(cyc);
      end
      if (pre_en) mem[pre_addr] <= pre_data;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input int a, input int d);
      pre_en = 1; pre_addr = a; pre_data = NW'(d);
      tick;
      pre_en = 0;
      exp_mem[a] = d;
   endtask

   task automatic pulse_clear;
      clear_status = 1;
      tick;
      clear_status = 0;
      exp_ovf = 0; exp_sync = 0;
   endtask

   // one sweep; sync_k/dis_k inject a stray start / drop enable at that dwell cycle index
   task automatic run_sweep(input int d, input int l, input int sync_k, input int dis_k);
      int de, n, t, wb, rb, cnt, nv;
      bit ovf;
      de = d < 4 ? 4 : d;
      n = (l + 1) * de;
      wb = wr_addr.size(); rb = rd_cyc.size();
      dwell = DW'(d); last_channel = CW'(l);
      tick;
      start = 1; t = cyc;
      tick;
      start = 0;
      for (int k = 0; k < n; k++) begin
         vectors++;
         if (channel !== CW'(k / de) || channel_advance !== (k % de == 0) || busy !== 1'b1) begin
            errors++;
            $display("FAIL sweep_k%0d: ch=%0d adv=%0b busy=%0b, expected ch=%0d adv=%0b busy=1",
                     k, channel, channel_advance, busy, k / de, k % de == 0);
         end
         detector_pulse = pat[k];
         start = (k == sync_k);
         if (k == dis_k) enable = 0;
         tick;
      end
      detector_pulse = 0; start = 0;
      exp_cycles++;
      vectors++;
      if (cycle_count !== 32'(exp_cycles)) begin
         errors++;
         $display("FAIL cycle_count: got %0d expected %0d", cycle_count, exp_cycles);
      end
      tick; tick;
      vectors++;
      if (busy !== 1'b1 || mem_wr !== 1'b1) begin
         errors++;
         $display("FAIL final_wr_busy: busy=%0b mem_wr=%0b expected 1/1", busy, mem_wr);
      end
      tick;
      vectors++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_fall: got %0b expected 0", busy);
      end
      ovf = 0;
      vectors++;
      if (wr_addr.size() - wb != l + 1 || rd_cyc.size() - rb != l + 1) begin
         errors++;
         $display("FAIL write_count: got %0d writes %0d reads expected %0d",
                  wr_addr.size() - wb, rd_cyc.size() - rb, l + 1);
      end
      for (int i = 0; i <= l; i++) begin
         cnt = 0;
         for (int k = i * de; k < (i + 1) * de; k++) cnt += int'(pat[k]);
         if (cnt > MAXP) begin cnt = MAXP; ovf = 1; end
         nv = exp_mem[i] + cnt;
         if (nv > MAXC) begin nv = MAXC; ovf = 1; end
         exp_mem[i] = nv;
         if (wb + i < wr_addr.size() && rb + i < rd_cyc.size()) begin
            vectors++;
            if (wr_addr[wb+i] != i || wr_data[wb+i] != nv || wr_cyc[wb+i] != t + (i + 1) * de + 3 ||
                rd_cyc[rb+i] != t + (i + 1) * de + 1) begin
               errors++;
               $display("FAIL rmw_ch%0d: addr=%0d data=%0h wr@%0d rd@%0d expected addr=%0d data=%0h wr@%0d rd@%0d",
                        i, wr_addr[wb+i], wr_data[wb+i], wr_cyc[wb+i] - t, rd_cyc[rb+i] - t,
                        i, nv, (i + 1) * de + 3, (i + 1) * de + 1);
            end
         end
      end
      exp_ovf |= ovf;
      if (sync_k >= 0 && sync_k < n) exp_sync = 1;
      vectors++;
      if (overflow !== exp_ovf || sync_err !== exp_sync || clash != 0) begin
         errors++;
         $display("FAIL flags: ovf=%0b sync=%0b clash=%0d expected ovf=%0b sync=%0b clash=0",
                  overflow, sync_err, clash, exp_ovf, exp_sync);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      vectors++;
      if ({mem_addr, mem_rd, mem_wr, mem_wdata, channel, channel_advance, cycle_count, busy, overflow, sync_err} !== '0) begin
         errors++;
         $display("FAIL %s: addr=%0h rd=%0b wr=%0b wdata=%0h ch=%0d adv=%0b cc=%0d busy=%0b ovf=%0b sync=%0b expected all 0",
                  name, mem_addr, mem_rd, mem_wr, mem_wdata, channel, channel_advance, cycle_count, busy, overflow, sync_err);
      end
   endtask

   task automatic test_reset;
      rst_n = 0;
      tick; tick;
      check_outputs_zero("reset");
      rst_n = 1;
      tick;
   endtask

   task automatic fill_counts(input int de, input int c0, input int c1, input int c2, input int c3);
      int c[4];
      c = '{c0, c1, c2, c3};
      pat = new[4 * de];
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < de; k++) pat[i*de+k] = (k < c[i]);
   endtask

   task automatic test_basic;
      enable = 1;
      fill_counts(8, 2, 0, 5, 1);
      run_sweep(8, 3, -1, -1);
   endtask

   task automatic test_accum;
      int want[4];
      want = '{4, 0, 10, 2};
      run_sweep(8, 3, -1, -1);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (int'(mem[i]) != want[i]) begin
            errors++;
            $display("FAIL accum_mem%0d: got %0d expected %0d", i, mem[i], want[i]);
         end
      end
   endtask

   task automatic test_random;
      int d, l;
      for (int s = 0; s < 5; s++) begin
         d = $urandom_range(0, 9);
         l = $urandom_range(0, 5);
         pat = new[(l + 1) * (d < 4 ? 4 : d)];
         foreach (pat[k]) pat[k] = bit'($urandom_range(0, 1));
         run_sweep(d, l, -1, -1);
      end
   endtask

   task automatic test_saturation;
      preload(0, 'hFFFFFE);
      pat = new[4];
      foreach (pat[k]) pat[k] = (k < 3);
      run_sweep(4, 0, -1, -1);
      vectors++;
      if (mem_wdata !== 24'hFFFFFF || overflow !== 1'b1) begin
         errors++;
         $display("FAIL mem_saturate: wdata=%0h ovf=%0b expected ffffff/1", mem_wdata, overflow);
      end
      pulse_clear;
      vectors++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL clear_overflow: got %0b expected 0", overflow);
      end
      preload(0, 0);
      pat = new[300];
      foreach (pat[k]) pat[k] = 1;
      run_sweep(300, 0, -1, -1);
      vectors++;
      if (int'(mem[0]) != MAXP) begin
         errors++;
         $display("FAIL pulse_saturate: got %0d expected %0d", mem[0], MAXP);
      end
      pulse_clear;
   endtask

   task automatic test_clamp;
      pat = new[12];
      foreach (pat[k]) pat[k] = (k == 3 || k == 4);
      run_sweep(1, 2, -1, -1);
   endtask

   task automatic test_sync;
      int rb;
      pat = new[24];
      foreach (pat[k]) pat[k] = bit'($urandom_range(0, 1));
      run_sweep(6, 3, 10, 15);
      pulse_clear;
      vectors++;
      if (sync_err !== 1'b0) begin
         errors++;
         $display("FAIL clear_sync: got %0b expected 0", sync_err);
      end
      rb = rd_cyc.size();
      start = 1;
      tick;
      start = 0;
      for (int k = 0; k < 8; k++) begin
         vectors++;
         if (busy !== 1'b0 || channel_advance !== 1'b0 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL idle_start_k%0d: busy=%0b adv=%0b sync=%0b expected 0/0/0", k, busy, channel_advance, sync_err);
         end
         tick;
      end
      vectors++;
      if (rd_cyc.size() != rb) begin
         errors++;
         $display("FAIL idle_start_rd: got %0d reads expected 0", rd_cyc.size() - rb);
      end
   endtask

   task automatic test_reset_mid_rmw;
      int wb, rb;
      enable = 1;
      dwell = 4; last_channel = 0;
      tick; tick;
      wb = wr_addr.size(); rb = rd_cyc.size();
      start = 1;
      tick;
      start = 0; detector_pulse = 1;
      tick;
      detector_pulse = 0;
      repeat (4) tick;
      vectors++;
      if (rd_cyc.size() - rb != 1) begin
         errors++;
         $display("FAIL pre_reset_rd: got %0d reads expected 1", rd_cyc.size() - rb);
      end
      rst_n = 0; enable = 0;
      #1;
      check_outputs_zero("async_reset");
      tick; tick;
      rst_n = 1;
      exp_cycles = 0; exp_ovf = 0; exp_sync = 0;
      rb = rd_cyc.size();
      tick;
      start = 1;
      tick;
      start = 0;
      repeat (8) tick;
      vectors++;
      if (wr_addr.size() != wb || rd_cyc.size() != rb || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_quiet: writes=%0d reads=%0d busy=%0b expected 0/0/0",
                  wr_addr.size() - wb, rd_cyc.size() - rb, busy);
      end
      enable = 1;
      pat = new[8];
      foreach (pat[k]) pat[k] = bit'($urandom_range(0, 1));
      run_sweep(4, 1, -1, -1);
   endtask

   initial begin
      foreach (exp_mem[i]) exp_mem[i] = 0;
      test_reset;
      test_basic;
      test_accum;
      test_random;
      test_saturation;
      test_clamp;
      test_sync;
      test_reset_mid_rmw;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
